// File: rtl/msi_arbiter_wb_if.sv
// msi_arbiter_wb_if: master-facing and slave-facing Wishbone signals of the arbiter
interface msi_arbiter_wb_if #(
   parameter int NUM_MASTERS = 5,
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [NUM_MASTERS-1:0][AW-1:0]   wbm_adr_i;
   logic [NUM_MASTERS-1:0][DW-1:0]   wbm_dat_i;
   logic [NUM_MASTERS-1:0][DW/8-1:0] wbm_sel_i;
   logic [NUM_MASTERS-1:0]           wbm_we_i;
   logic [NUM_MASTERS-1:0]           wbm_cyc_i;
   logic [NUM_MASTERS-1:0]           wbm_stb_i;
   logic [NUM_MASTERS-1:0][2:0]      wbm_cti_i;
   logic [NUM_MASTERS-1:0][1:0]      wbm_bte_i;
   logic [NUM_MASTERS-1:0][DW-1:0]   wbm_dat_o;
   logic [NUM_MASTERS-1:0]           wbm_ack_o;
   logic [NUM_MASTERS-1:0]           wbm_err_o;
   logic [NUM_MASTERS-1:0]           wbm_rty_o;
   logic [AW-1:0]                    wbs_adr_o;
   logic [DW-1:0]                    wbs_dat_o;
   logic [DW/8-1:0]                  wbs_sel_o;
   logic                             wbs_we_o;
   logic                             wbs_cyc_o;
   logic                             wbs_stb_o;
   logic [2:0]                       wbs_cti_o;
   logic [1:0]                       wbs_bte_o;
   logic [DW-1:0]                    wbs_dat_i;
   logic                             wbs_ack_i;
   logic                             wbs_err_i;
   logic                             wbs_rty_i;
   // slave: the arbiter's own view; master: the surrounding masters plus shared slave
   modport slave (
      input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
      input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
      output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o
   );
   modport master (
      output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
      output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
      input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o
   );
endinterface

// File: rtl/msi_arbiter_wb.sv
// msi_arbiter_wb: round-robin N-to-1 Wishbone arbiter that holds the grant for a whole cyc burst
module msi_arbiter_wb #(
   parameter int NUM_MASTERS = 5,
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic             wb_clk_i,
   input logic             wb_rst_i,
   msi_arbiter_wb_if.slave bus
);
   localparam int SW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
   logic [NUM_MASTERS-1:0] grant, req;
   logic [SW-1:0] sel, last, nxt;
   logic active;
   function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] l, input logic [NUM_MASTERS-1:0] r);
      int j;
      rr_next = l;
      // descending scan: the closest requester after l is written last and wins
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         j = (int'(l) + i) % NUM_MASTERS;
         if (r[SW'(j)]) rr_next = SW'(j);
      end
   endfunction
   assign req = bus.wbm_cyc_i;
   assign active = |grant;
   assign nxt = rr_next(last, req);
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         grant <= '0;
         sel <= '0;
         last <= SW'(NUM_MASTERS - 1);
      end else if (!(active && req[sel])) begin
         grant <= (|req) ? NUM_MASTERS'(1) << nxt : '0;
         if (|req) begin
            sel <= nxt;
            last <= nxt;
         end
      end
   assign bus.wbs_adr_o = AW'(bus.wbm_adr_i[sel]);
   assign bus.wbs_dat_o = DW'(bus.wbm_dat_i[sel]);
   assign bus.wbs_sel_o = (DW/8)'(bus.wbm_sel_i[sel]);
   assign bus.wbs_we_o  = bus.wbm_we_i[sel];
   assign bus.wbs_cti_o = bus.wbm_cti_i[sel];
   assign bus.wbs_bte_o = bus.wbm_bte_i[sel];
   assign bus.wbs_cyc_o = bus.wbm_cyc_i[sel] & active;
   assign bus.wbs_stb_o = bus.wbm_stb_i[sel] & active;
   assign bus.wbm_dat_o = {NUM_MASTERS{bus.wbs_dat_i}};
   assign bus.wbm_ack_o = {NUM_MASTERS{bus.wbs_ack_i}} & grant;
   assign bus.wbm_err_o = {NUM_MASTERS{bus.wbs_err_i}} & grant;
   assign bus.wbm_rty_o = {NUM_MASTERS{bus.wbs_rty_i}} & grant;
endmodule

// File: tb/tb_msi_arbiter_wb.sv
// tb_msi_arbiter_wb: directed scenarios plus a randomized multi-master memory soak for msi_arbiter_wb
module tb_msi_arbiter_wb;
   localparam int N = 5, AW = 32, DW = 32, NTX = 1000, BOUND = 40;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, passed = 0;
   logic auto_slave = 1'b0, auto_ack = 1'b0;
   logic man_ack = 1'b0, man_err = 1'b0, man_rty = 1'b0;
   logic [DW-1:0] man_dat = '0, auto_dat = '0;
   bit [31:0] mem [2048];
   bit [31:0] model [N][256];
   msi_arbiter_wb_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();
   msi_arbiter_wb #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   assign bus.wbs_ack_i = auto_slave ? auto_ack : man_ack;
   assign bus.wbs_err_i = !auto_slave && man_err;
   assign bus.wbs_rty_i = !auto_slave && man_rty;
   assign bus.wbs_dat_i = auto_slave ? auto_dat : man_dat;
   // memory slave: acks one cycle after it sees a strobe, byte-lane writes
   always @(posedge clk)
      if (auto_slave && bus.wbs_cyc_o && bus.wbs_stb_o && !auto_ack) begin
         auto_ack <= 1'b1;
         auto_dat <= mem[bus.wbs_adr_o[12:2]];
         if (bus.wbs_we_o)
            for (int b = 0; b < 4; b++)
               if (bus.wbs_sel_o[b]) mem[bus.wbs_adr_o[12:2]][8*b +: 8] <= bus.wbs_dat_o[8*b +: 8];
      end else auto_ack <= 1'b0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we, input logic [2:0] cti);
      bus.wbm_adr_i[m] = a;
      bus.wbm_dat_i[m] = d;
      bus.wbm_sel_i[m] = '1;
      bus.wbm_we_i[m] = we;
      bus.wbm_cti_i[m] = cti;
      bus.wbm_bte_i[m] = 2'b00;
      bus.wbm_cyc_i[m] = 1'b1;
      bus.wbm_stb_i[m] = 1'b1;
   endtask
   task automatic drop(input int m);
      bus.wbm_cyc_i[m] = 1'b0;
      bus.wbm_stb_i[m] = 1'b0;
   endtask
   task automatic master_run(input int m);
      int waited;
      logic [7:0] w;
      logic [31:0] d;
      logic [3:0] s;
      logic we;
      for (int n = 0; n < NTX; n++) begin
         w = 8'($urandom);
         d = $urandom;
         s = 4'($urandom);
         we = 1'($urandom_range(0, 1));
         bus.wbm_adr_i[m] = 32'(m * 1024 + int'(w) * 4);
         bus.wbm_dat_i[m] = d;
         bus.wbm_sel_i[m] = s;
         bus.wbm_we_i[m] = we;
         bus.wbm_cti_i[m] = 3'b111;
         bus.wbm_bte_i[m] = 2'b00;
         bus.wbm_cyc_i[m] = 1'b1;
         bus.wbm_stb_i[m] = 1'b1;
         waited = 0;
         do begin
            @(posedge clk);
            #2;
            waited++;
         end while (!bus.wbm_ack_o[m] && waited < BOUND);
         chk($sformatf("soak_ack_within_bound_m%0d", m), 64'(bus.wbm_ack_o[m]), 64'(1));
         chk($sformatf("soak_ack_onehot_m%0d", m), 64'(bus.wbm_ack_o), 64'(1) << m);
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) model[m][w][8*b +: 8] = d[8*b +: 8];
         end else chk($sformatf("soak_rdata_m%0d_w%0d", m, w), 64'(bus.wbm_dat_o[m]), 64'(model[m][w]));
         @(posedge clk);
         #1;
         drop(m);
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog timeout");
   end
   initial begin
      bus.wbm_adr_i = '0; bus.wbm_dat_i = '0; bus.wbm_sel_i = '0; bus.wbm_we_i = '0;
      bus.wbm_cyc_i = '0; bus.wbm_stb_i = '0; bus.wbm_cti_i = '0; bus.wbm_bte_i = '0;
      for (int m = 0; m < N; m++) req(m, 32'('h1111_0000 * (m + 1)), 32'(m), 1'b0, 3'b111);
      man_ack = 1'b1; man_err = 1'b1; man_rty = 1'b1;
      step(); step(); #1;
      chk("rst_wbs_cyc", 64'(bus.wbs_cyc_o), 64'(0));
      chk("rst_wbs_stb", 64'(bus.wbs_stb_o), 64'(0));
      chk("rst_ack", 64'(bus.wbm_ack_o), 64'(0));
      chk("rst_err", 64'(bus.wbm_err_o), 64'(0));
      chk("rst_rty", 64'(bus.wbm_rty_o), 64'(0));
      chk("rst_mirror_adr", 64'(bus.wbs_adr_o), 64'h1111_0000);
      rst = 1'b0; man_err = 1'b0; man_rty = 1'b0;
      step(); #1;
      chk("first_grant_adr", 64'(bus.wbs_adr_o), 64'h1111_0000);
      chk("first_grant_cyc", 64'(bus.wbs_cyc_o), 64'(1));
      chk("first_grant_ack", 64'(bus.wbm_ack_o), 64'b00001);
      #1 rst = 1'b1;
      #1;
      chk("midrst_wbs_cyc", 64'(bus.wbs_cyc_o), 64'(0));
      chk("midrst_ack", 64'(bus.wbm_ack_o), 64'(0));
      for (int m = 0; m < N; m++) drop(m);
      man_ack = 1'b0;
      step();
      rst = 1'b0;
      req(2, 32'h208, 32'hDEAD_BEEF, 1'b1, 3'b111);
      #1;
      chk("sw_pre_grant_cyc", 64'(bus.wbs_cyc_o), 64'(0));
      step(); #1;
      chk("sw_adr", 64'(bus.wbs_adr_o), 64'h208);
      chk("sw_dat", 64'(bus.wbs_dat_o), 64'hDEAD_BEEF);
      chk("sw_sel", 64'(bus.wbs_sel_o), 64'hF);
      chk("sw_we", 64'(bus.wbs_we_o), 64'(1));
      chk("sw_cyc", 64'(bus.wbs_cyc_o), 64'(1));
      chk("sw_stb", 64'(bus.wbs_stb_o), 64'(1));
      chk("sw_ack_before_slave", 64'(bus.wbm_ack_o), 64'(0));
      man_ack = 1'b1;
      #1;
      chk("sw_ack_only_m2", 64'(bus.wbm_ack_o), 64'b00100);
      step();
      man_ack = 1'b0;
      drop(2);
      #1;
      chk("sw_ack_released", 64'(bus.wbm_ack_o), 64'(0));
      rst = 1'b1;
      #1 rst = 1'b0;
      step();
      for (int m = 0; m < N; m++) req(m, 32'('h100 * (m + 1)), 32'(0), 1'b0, 3'b111);
      for (int k = 0; k < 6; k++) begin
         step();
         if (k == 1) req(0, 32'h100, 32'(0), 1'b0, 3'b111);
         #1;
         chk($sformatf("rr_grant_adr%0d", k), 64'(bus.wbs_adr_o), 64'('h100 * (k % N + 1)));
         chk($sformatf("rr_grant_cyc%0d", k), 64'(bus.wbs_cyc_o), 64'(1));
         man_ack = 1'b1;
         #1;
         chk($sformatf("rr_ack%0d", k), 64'(bus.wbm_ack_o), 64'(1) << (k % N));
         step();
         man_ack = 1'b0;
         drop(k % N);
      end
      req(1, 32'h40, 32'(0), 1'b0, 3'b010);
      req(3, 32'h300, 32'(0), 1'b0, 3'b111);
      step(); #1;
      chk("burst_grant_adr", 64'(bus.wbs_adr_o), 64'h40);
      chk("burst_cti", 64'(bus.wbs_cti_o), 64'b010);
      chk("burst_bte", 64'(bus.wbs_bte_o), 64'b00);
      for (int b = 0; b < 4; b++) begin
         bus.wbm_adr_i[1] = 32'('h40 + 4 * b);
         bus.wbm_cti_i[1] = (b == 3) ? 3'b111 : 3'b010;
         man_ack = 1'b1;
         #1;
         chk($sformatf("burst_beat_adr%0d", b), 64'(bus.wbs_adr_o), 64'('h40 + 4 * b));
         chk($sformatf("burst_beat_ack%0d", b), 64'(bus.wbm_ack_o), 64'b00010);
         step();
      end
      man_ack = 1'b0;
      drop(1);
      #1;
      chk("burst_end_no_ack", 64'(bus.wbm_ack_o), 64'(0));
      chk("burst_end_cyc_low", 64'(bus.wbs_cyc_o), 64'(0));
      step(); #1;
      chk("burst_m3_adr", 64'(bus.wbs_adr_o), 64'h300);
      chk("burst_m3_cyc", 64'(bus.wbs_cyc_o), 64'(1));
      man_ack = 1'b1;
      #1;
      chk("burst_m3_ack", 64'(bus.wbm_ack_o), 64'b01000);
      step();
      man_ack = 1'b0;
      drop(3);
      req(4, 32'h400, 32'(0), 1'b0, 3'b111);
      step();
      man_dat = 32'hCAFE_F00D;
      man_err = 1'b1;
      #1;
      chk("err_only_m4", 64'(bus.wbm_err_o), 64'b10000);
      chk("err_no_ack", 64'(bus.wbm_ack_o), 64'(0));
      chk("err_no_rty", 64'(bus.wbm_rty_o), 64'(0));
      for (int k = 0; k < N; k++) chk($sformatf("err_dat_bcast%0d", k), 64'(bus.wbm_dat_o[k]), 64'hCAFE_F00D);
      step();
      man_err = 1'b0;
      man_rty = 1'b1;
      #1;
      chk("rty_only_m4", 64'(bus.wbm_rty_o), 64'b10000);
      chk("rty_no_err", 64'(bus.wbm_err_o), 64'(0));
      step();
      man_rty = 1'b0;
      drop(4);
      step();
      auto_slave = 1'b1;
      fork
         master_run(0);
         master_run(1);
         master_run(2);
         master_run(3);
         master_run(4);
      join
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
